// File: rtl/lcd_timing_gen.sv
// ---------------------------------------------------------------------------
// lcd_timing_gen
//
// Purpose:
//   Generates the sync, data-enable and pixel-request timing for a parallel
//   RGB LCD panel. One free-running pixel counter (h_cnt) and one line
//   counter (v_cnt) are the only timing state. Sync, data enable and the
//   pixel request coordinates are decoded from those two counters.
//
//   The pixel request (pixel_xpos/pixel_ypos) runs one cycle ahead of
//   lcd_de. This gives the upstream composition stage one registered
//   cycle to return pixel_data, which then lines up with lcd_de.
//
// Ports:
//   lcd_pclk     in   1   pixel clock (the only clock)
//   rst_n        in   1   synchronous reset, active-low
//   pixel_data   in  24   RGB888, registered upstream one cycle after xpos/ypos
//   pixel_xpos   out 11   column of the pixel being requested (0 when idle)
//   pixel_ypos   out 11   row of the pixel being requested (0 when idle)
//   h_disp       out 11   constant H_DISP
//   v_disp       out 11   constant V_DISP
//   lcd_hs       out  1   line sync, active-low
//   lcd_vs       out  1   frame sync, active-low
//   lcd_de       out  1   data enable, active-high
//   lcd_rgb      out 24   panel pixel bus (black outside lcd_de)
//   frame_start  out  1   registered one-cycle pulse at the frame origin
//
// Build option:
//   LCD_TEST_PATTERN_EN  when defined, lcd_rgb shows 8 vertical colour bars
//                        instead of pixel_data. When undefined, no pattern
//                        logic exists and pixel_data passes straight through.
// ---------------------------------------------------------------------------
module lcd_timing_gen #(
    parameter logic [10:0] H_SYNC  = 11'd41,
    parameter logic [10:0] H_BACK  = 11'd2,
    parameter logic [10:0] H_DISP  = 11'd480,
    parameter logic [10:0] H_FRONT = 11'd2,
    parameter logic [10:0] V_SYNC  = 11'd10,
    parameter logic [10:0] V_BACK  = 11'd2,
    parameter logic [10:0] V_DISP  = 11'd272,
    parameter logic [10:0] V_FRONT = 11'd2
) (
    input  logic        lcd_pclk,
    input  logic        rst_n,
    input  logic [23:0] pixel_data,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic [10:0] h_disp,
    output logic [10:0] v_disp,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic        lcd_de,
    output logic [23:0] lcd_rgb,
    output logic        frame_start
);

    localparam logic [10:0] H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam logic [10:0] V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    // Active window bounds (end values are exclusive).
    localparam logic [10:0] H_DE_START  = H_SYNC + H_BACK;
    localparam logic [10:0] H_DE_END    = H_DE_START + H_DISP;
    localparam logic [10:0] V_DE_START  = V_SYNC + V_BACK;
    localparam logic [10:0] V_DE_END    = V_DE_START + V_DISP;

    // The request window is the data-enable window moved one pixel earlier.
    localparam logic [10:0] H_REQ_START = H_DE_START - 11'd1;
    localparam logic [10:0] H_REQ_END   = H_DE_END - 11'd1;

    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic        h_last;
    logic        v_last;
    logic        v_active;
    logic        data_req;

    assign h_last = (h_cnt == H_TOTAL - 11'd1);
    assign v_last = (v_cnt == V_TOTAL - 11'd1);

    // The line counter only advances on the pixel counter's wrap cycle, so
    // the frame wraps when both counters sit at their maxima together.
    always_ff @(posedge lcd_pclk) begin
        if (!rst_n) begin
            h_cnt <= 11'd0;
            v_cnt <= 11'd0;
        end else begin
            h_cnt <= h_last ? 11'd0 : h_cnt + 11'd1;
            if (h_last) begin
                v_cnt <= v_last ? 11'd0 : v_cnt + 11'd1;
            end
        end
    end

    // frame_start is the registered copy of the origin decode, so it is
    // high in the cycle after h_cnt = v_cnt = 0. It is forced low in reset,
    // so the first pulse after release follows the first origin cycle.
    always_ff @(posedge lcd_pclk) begin
        if (!rst_n) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= (h_cnt == 11'd0) && (v_cnt == 11'd0);
        end
    end

    assign h_disp = H_DISP;
    assign v_disp = V_DISP;

    assign lcd_hs   = (h_cnt >= H_SYNC);
    assign lcd_vs   = (v_cnt >= V_SYNC);
    assign v_active = (v_cnt >= V_DE_START) && (v_cnt < V_DE_END);
    assign lcd_de   = (h_cnt >= H_DE_START) && (h_cnt < H_DE_END) && v_active;
    assign data_req = (h_cnt >= H_REQ_START) && (h_cnt < H_REQ_END) && v_active;

    assign pixel_xpos = data_req ? (h_cnt - H_REQ_START) : 11'd0;
    assign pixel_ypos = data_req ? (v_cnt - V_DE_START) : 11'd0;

`ifdef LCD_TEST_PATTERN_EN
    // Bar width is H_DISP/8. The guard keeps the divisor non-zero on very
    // narrow panels.
    localparam logic [10:0] BAND_W = (H_DISP < 11'd8) ? 11'd1 : (H_DISP >> 3);

    logic [10:0] col_d;
    logic [10:0] band;
    logic [23:0] bar_rgb;
    logic        unused_pixel_data;

    // The column is delayed one cycle so that the bars see the same request
    // latency as real pixel_data from the composition stage.
    always_ff @(posedge lcd_pclk) begin
        if (!rst_n) begin
            col_d <= 11'd0;
        end else begin
            col_d <= pixel_xpos;
        end
    end

    assign band = col_d / BAND_W;

    always_comb begin
        bar_rgb = 24'h000000;
        case (band)
            11'd0:   bar_rgb = 24'hFFFFFF;
            11'd1:   bar_rgb = 24'hFFFF00;
            11'd2:   bar_rgb = 24'h00FFFF;
            11'd3:   bar_rgb = 24'h00FF00;
            11'd4:   bar_rgb = 24'hFF00FF;
            11'd5:   bar_rgb = 24'hFF0000;
            11'd6:   bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    assign lcd_rgb           = lcd_de ? bar_rgb : 24'h000000;
    assign unused_pixel_data = ^pixel_data;
`else
    assign lcd_rgb = lcd_de ? pixel_data : 24'h000000;
`endif

endmodule

// File: doc/lcd_timing_gen.md
LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

Interface
REQ-001 Parameter H_SYNC, default 11'd41, horizontal sync width in pclk cycles.
REQ-002 Parameter H_BACK, default 11'd2, horizontal back porch.
REQ-003 Parameter H_DISP, default 11'd480, active pixels per line.
REQ-004 Parameter H_FRONT, default 11'd2, horizontal front porch.
REQ-005 Parameter V_SYNC, default 11'd10, vertical sync width in lines.
REQ-006 Parameter V_BACK, default 11'd2, vertical back porch.
REQ-007 Parameter V_DISP, default 11'd272, active lines per frame.
REQ-008 Parameter V_FRONT, default 11'd2, vertical front porch.
REQ-009 lcd_pclk  in  1  pixel clock; the only clock.
REQ-010 rst_n  in  1  synchronous reset, active-low.
REQ-011 pixel_data  in  24  RGB888 from the display-composition stage, registered there one cycle after pixel_xpos/pixel_ypos.
REQ-012 pixel_xpos  out  11  column of the pixel being requested.
REQ-013 pixel_ypos  out  11  row of the pixel being requested.
REQ-014 h_disp  out  11  constant H_DISP.
REQ-015 v_disp  out  11  constant V_DISP.
REQ-016 lcd_hs  out  1  line sync, active-low.
REQ-017 lcd_vs  out  1  frame sync, active-low.
REQ-018 lcd_de  out  1  data enable, active-high.
REQ-019 lcd_rgb  out  24  panel pixel bus.
REQ-020 frame_start  out  1  one-cycle pulse at frame origin.

Function
REQ-021 H_TOTAL = H_SYNC+H_BACK+H_DISP+H_FRONT (default 525); V_TOTAL = V_SYNC+V_BACK+V_DISP+V_FRONT (default 286); all counters 11 bits.
REQ-022 h_cnt increments every cycle, wraps H_TOTAL-1 -> 0.
REQ-023 v_cnt increments on the cycle h_cnt wraps, wraps V_TOTAL-1 -> 0 when both counters are at their maxima in that cycle.
REQ-024 lcd_hs = 0 while h_cnt < H_SYNC, else 1; lcd_vs = 0 while v_cnt < V_SYNC, else 1.
REQ-025 lcd_de = 1 iff h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP) and v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP).
REQ-026 data_req (internal) = same window as lcd_de but with h bounds shifted one cycle earlier: [H_SYNC+H_BACK-1, H_SYNC+H_BACK+H_DISP-1).
REQ-027 pixel_xpos = h_cnt-(H_SYNC+H_BACK-1) when data_req, else 0; pixel_ypos = v_cnt-(V_SYNC+V_BACK) when data_req, else 0.
REQ-028 Net latency: the pixel requested at cycle t appears on lcd_rgb at t+1 under lcd_de; xpos 0 is on lcd_rgb at h_cnt = H_SYNC+H_BACK.
REQ-029 lcd_rgb = pixel_data when lcd_de, else 24'h000000.
REQ-030 frame_start is registered; high for exactly one cycle following the cycle with h_cnt=0 and v_cnt=0.
REQ-031 Sync, de, xpos and ypos are combinational decodes of the registered counters; no glitch-sensitive logic on other signals.

Reset
REQ-032 While rst_n=0 at a clock edge: h_cnt=0, v_cnt=0, frame_start=0.
REQ-033 Resulting output values during reset: lcd_hs=0, lcd_vs=0, lcd_de=0, lcd_rgb=0, pixel_xpos=0, pixel_ypos=0.
REQ-034 Reset asserted mid-frame aborts the frame; the first cycle after release is h_cnt=0, v_cnt=0, and the next frame_start pulse follows it.

Configuration
REQ-035 Macro LCD_TEST_PATTERN_EN defined: lcd_rgb under lcd_de ignores pixel_data and shows 8 vertical colour bars, band = column/(H_DISP/8), colours in order FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
REQ-036 Column for REQ-035 is a registered copy of pixel_xpos, matching the pixel_data latency.
REQ-037 Macro undefined: no pattern logic is synthesised; REQ-029 applies.

Verification
REQ-038 Free-run defaults: lcd_hs low for 41 of every 525 cycles; lcd_vs low for 10x525 of every 286x525 cycles.
REQ-039 Count lcd_de per frame -> 480 per line, 272 lines, 130560 total; first de at h_cnt=43, v_cnt=12.
REQ-040 Drive pixel_data = {13'd0,pixel_xpos} registered one cycle -> lcd_rgb low 11 bits read 0..479 per active line, no skips or repeats.
REQ-041 Assert rst_n=0 for 3 cycles at v_cnt=100 -> all outputs at REQ-033 values; frame_start pulses one cycle after release; next de after 43+12x525 cycles.
REQ-042 LCD_TEST_PATTERN_EN defined -> lcd_rgb at columns 0, 59, 60, 479 = FFFFFF, FFFFFF, FFFF00, 000000.
REQ-043 Parameters H 4/1/8/1, V 2/1/4/1 -> H_TOTAL 14, V_TOTAL 8, frame_start period 112 cycles.
